// File: rtl/sync_deglitch.sv
// sync_deglitch
//   Synchronizing deglitch filter for a single-bit level, typically taken
//   straight from an inverter on a noisy or asynchronous pin. The level is
//   re-timed through a SYNC_STAGES flop chain. The filtered output Z only
//   follows a new value once that value has held for FILT_LEN consecutive
//   enabled cycles. ZR and ZF are one-cycle strobes on Z rise and fall.
//
// Parameters
//   SYNC_STAGES  synchronizer depth, 1..4
//   FILT_LEN     enabled cycles a changed level must persist, 1..256
//   INIT         reset value of the synchronizer chain and of Z
//
// Ports
//   CK   clock, rising edge
//   CD   synchronous active-high clear, wins over SP
//   SP   clock enable; when low, all state holds and strobes drop
//   A    raw level to be filtered
//   Z    filtered level (registered)
//   ZR   one-cycle strobe on Z 0->1 (registered)
//   ZF   one-cycle strobe on Z 1->0 (registered)

module sync_deglitch #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter logic        INIT        = 1'b0
) (
  input  logic CK,
  input  logic CD,
  input  logic SP,
  input  logic A,
  output logic Z,
  output logic ZR,
  output logic ZF
);

  // Counter is sized for FILT_LEN-1. It never wraps because the terminal
  // value always triggers the Z update together with the clear.
  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] s;
  logic [CW-1:0]          cnt;
  logic                   s_last;

  assign s_last = s[SYNC_STAGES-1];

  // Synchronizer chain. With SYNC_STAGES == 1, the loop body does not run
  // and the chain is a single flop.
  always_ff @(posedge CK) begin
    if (CD) begin
      s <= {SYNC_STAGES{INIT}};
    end else if (SP) begin
      s[0] <= A;
      for (int i = 1; i < int'(SYNC_STAGES); i++) s[i] <= s[i-1];
    end
  end

  // Filter. This block compares Z against the pre-edge s_last, so the chain
  // shift and the count both advance on the same enabled edge. Strobes
  // default low every cycle, so they cannot persist through a disabled
  // cycle.
  always_ff @(posedge CK) begin
    if (CD) begin
      Z   <= INIT;
      cnt <= '0;
      ZR  <= 1'b0;
      ZF  <= 1'b0;
    end else begin
      ZR <= 1'b0;
      ZF <= 1'b0;
      if (SP) begin
        if (s_last == Z) begin
          cnt <= '0;                 // level fell back: glitch rejected
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end else begin
          Z   <= s_last;
          cnt <= '0;
          ZR  <= s_last;
          ZF  <= ~s_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_deglitch.sv
// Directed bench for sync_deglitch with three instances: the default
// configuration, FILT_LEN=1/SYNC_STAGES=1, and FILT_LEN=256/SYNC_STAGES=1.
// "after edge n" means sampled 1 time unit after the nth rising edge.

module tb_sync_deglitch;

  logic ck;
  logic cd0, sp0, a0, z0, zr0, zf0;
  logic cd1, sp1, a1, z1, zr1, zf1;
  logic cd2, sp2, a2, z2, zr2, zf2;

  int checks = 0;
  int errs   = 0;

  sync_deglitch dut0 (
    .CK(ck), .CD(cd0), .SP(sp0), .A(a0), .Z(z0), .ZR(zr0), .ZF(zf0)
  );

  sync_deglitch #(.SYNC_STAGES(1), .FILT_LEN(1)) dut1 (
    .CK(ck), .CD(cd1), .SP(sp1), .A(a1), .Z(z1), .ZR(zr1), .ZF(zf1)
  );

  sync_deglitch #(.SYNC_STAGES(1), .FILT_LEN(256)) dut2 (
    .CK(ck), .CD(cd2), .SP(sp2), .A(a2), .Z(z2), .ZR(zr2), .ZF(zf2)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk0(input string name, input int n, input logic ez, input logic er, input logic ef);
    chk($sformatf("%s Z e%0d", name, n),  32'(z0),  32'(ez));
    chk($sformatf("%s ZR e%0d", name, n), 32'(zr0), 32'(er));
    chk($sformatf("%s ZF e%0d", name, n), 32'(zf0), 32'(ef));
  endtask

  // Single clear edge on dut0, with the next edge being edge 1 of a test.
  task automatic clear0();
    cd0 = 1'b1;
    sp0 = 1'b1;
    tick();
    chk0("clr", 0, 1'b0, 1'b0, 1'b0);
    cd0 = 1'b0;
  endtask

  logic [0:8] av1, ze1, zre1, zfe1;

  initial begin
    cd0 = 1'b1; sp0 = 1'b1; a0 = 1'b1;
    cd1 = 1'b1; sp1 = 1'b1; a1 = 1'b0;
    cd2 = 1'b1; sp2 = 1'b1; a2 = 1'b0;

    // The reset holds Z at INIT while A is already high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk0("rst", i, 1'b0, 1'b0, 1'b0);
    end
    cd0 = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk0("rel", n, n >= 6, n == 6, 1'b0);
    end

    // Clean rise before edge 10 and fall before edge 30.
    a0 = 1'b0;
    clear0();
    for (int n = 1; n <= 40; n++) begin
      a0 = (n >= 10 && n < 30);
      tick();
      chk0("clean", n, (n >= 15 && n < 35), n == 15, n == 35);
    end

    // A 3-cycle pulse is rejected.
    a0 = 1'b0;
    clear0();
    for (int n = 1; n <= 12; n++) begin
      a0 = (n <= 3);
      tick();
      chk0("g3", n, 1'b0, 1'b0, 1'b0);
    end

    // A 4-cycle pulse passes. It holds Z high for 4 cycles, then Z falls.
    a0 = 1'b0;
    clear0();
    for (int n = 1; n <= 14; n++) begin
      a0 = (n <= 4);
      tick();
      chk0("g4", n, (n >= 6 && n <= 9), n == 6, n == 10);
    end

    // With SP low for edges 5..9 after two counted cycles, the rise moves
    // from edge 6 to edge 11.
    a0 = 1'b1;
    clear0();
    for (int n = 1; n <= 13; n++) begin
      sp0 = !(n >= 5 && n <= 9);
      tick();
      chk0("sp", n, n >= 11, n == 11, 1'b0);
    end
    sp0 = 1'b1;

    // CD (with SP low, so CD has priority) at edge 5, once cnt has reached 2.
    // The filter restarts, and Z rises 6 edges after release (edge 11).
    a0 = 1'b1;
    clear0();
    for (int n = 1; n <= 12; n++) begin
      cd0 = (n == 5);
      sp0 = (n != 5);
      tick();
      if (n == 4) chk("mid cnt e4", 32'(dut0.cnt), 32'd2);
      if (n == 5) chk("mid cnt e5", 32'(dut0.cnt), 32'd0);
      chk0("mid", n, n >= 11, n == 11, 1'b0);
    end
    cd0 = 1'b0;
    sp0 = 1'b1;

    // FILT_LEN=1, SYNC_STAGES=1: Z after edge n equals A from before edge
    // n-1, so every single-cycle pulse propagates.
    av1  = 9'b101101000;
    ze1  = 9'b010110100;
    zre1 = 9'b010100100;
    zfe1 = 9'b001001010;
    tick();
    chk("c1 clr Z", 32'(z1), 32'd0);
    cd1 = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      a1 = av1[n-1];
      tick();
      chk($sformatf("c1 Z e%0d", n),  32'(z1),  32'(ze1[n-1]));
      chk($sformatf("c1 ZR e%0d", n), 32'(zr1), 32'(zre1[n-1]));
      chk($sformatf("c1 ZF e%0d", n), 32'(zf1), 32'(zfe1[n-1]));
    end

    // FILT_LEN=256: cnt climbs to 255 and Z rises after edge 257.
    a2 = 1'b1;
    tick();
    chk("c256 clr Z", 32'(z2), 32'd0);
    cd2 = 1'b0;
    for (int n = 1; n <= 258; n++) begin
      tick();
      if (n == 128) chk("c256 cnt e128", 32'(dut2.cnt), 32'd127);
      if (n == 256) begin
        chk("c256 cnt e256", 32'(dut2.cnt), 32'd255);
        chk("c256 Z e256", 32'(z2), 32'd0);
      end
      if (n == 257) begin
        chk("c256 Z e257", 32'(z2), 32'd1);
        chk("c256 ZR e257", 32'(zr2), 32'd1);
        chk("c256 cnt e257", 32'(dut2.cnt), 32'd0);
      end
      if (n == 258) begin
        chk("c256 ZR e258", 32'(zr2), 32'd0);
        chk("c256 Z e258", 32'(z2), 32'd1);
      end
      if (n != 257) chk($sformatf("c256 ZR e%0d", n), 32'(zr2), 32'd0);
      chk($sformatf("c256 ZF e%0d", n), 32'(zf2), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
